// File: rtl/user_io_pkg.sv
// user_io_pkg: mode encoding and synchroniser depth limits shared by the user IO bridge.
package user_io_pkg;
  typedef enum logic [1:0] {PASS = 2'b00, SYNC = 2'b01, REG = 2'b10, LOOP = 2'b11} io_mode_t;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  function automatic int clamp_stages(input int n);
    return n < SYNC_STAGES_MIN ? SYNC_STAGES_MIN : n > SYNC_STAGES_MAX ? SYNC_STAGES_MAX : n;
  endfunction
endpackage

// File: rtl/user_io_sync.sv
// user_io_sync: single-channel synchroniser for an asynchronous pin, plus a stability
// debouncer when USER_IO_DEBOUNCE_EN is defined.
module user_io_sync
  import user_io_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CNT_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic filt
);
  localparam int STAGES = clamp_stages(SYNC_STAGES);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[STAGES-2:0], din};
`ifdef USER_IO_DEBOUNCE_EN
  logic [DEB_CNT_W-1:0] cnt;
  logic deb;
  // the counter only runs while the synced value disagrees with the accepted one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync_q[STAGES-1] == deb) begin
      cnt <= '0;
    end else if (&cnt) begin
      deb <= sync_q[STAGES-1];
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  assign filt = deb;
`else
  assign filt = sync_q[STAGES-1];
`endif
endmodule

// File: rtl/user_io_bridge.sv
// user_io_bridge: per-channel mode-selectable bridge between user pins and fabric ports
// with sticky rising-edge flags; USER_IO_DEBOUNCE_EN adds a debouncer on every input.
module user_io_bridge
  import user_io_pkg::*;
#(
  parameter int NUM_CH      = 20,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CNT_W   = 4
) (
  input  logic                  UserCLK,
  input  logic                  resetn,
  input  logic [NUM_CH-1:0]     UIN,
  output logic [NUM_CH-1:0]     UOUT,
  input  logic [NUM_CH-1:0]     FIN,
  output logic [NUM_CH-1:0]     FOUT,
  input  logic [2*NUM_CH-1:0]   cfg_mode,
  output logic [NUM_CH-1:0]     edge_flag,
  input  logic [NUM_CH-1:0]     edge_clr
);
  logic [NUM_CH-1:0] filt, prev, fin_q;
  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      io_mode_t mode;
      assign mode = io_mode_t'(cfg_mode[2*i +: 2]);
      user_io_sync #(.SYNC_STAGES(SYNC_STAGES), .DEB_CNT_W(DEB_CNT_W)) u_sync (
        .clk  (UserCLK),
        .rst_n(resetn),
        .din  (UIN[i]),
        .filt (filt[i])
      );
      // fin_q serves both REG (toward pins) and LOOP (back to fabric)
      assign UOUT[i] = mode == LOOP ? 1'b0 : mode == REG ? fin_q[i] : FIN[i];
      assign FOUT[i] = mode == PASS ? UIN[i] : mode == LOOP ? fin_q[i] : filt[i];
    end
  endgenerate
  // set beats clear so a rise coinciding with a clear is never lost
  always_ff @(posedge UserCLK or negedge resetn)
    if (!resetn) begin
      prev      <= '0;
      fin_q     <= '0;
      edge_flag <= '0;
    end else begin
      prev      <= filt;
      fin_q     <= FIN;
      edge_flag <= (filt & ~prev) | (edge_flag & ~edge_clr);
    end
endmodule

// File: tb/tb_user_io_bridge.sv
// tb_user_io_bridge: randomized and directed checks of user_io_bridge against a pin-history model.
module tb_user_io_bridge;
  localparam int NUM_CH = 20, SYNC_STAGES = 2, DEB_CNT_W = 4;
`ifdef USER_IO_DEBOUNCE_EN
  localparam int DEB_WIN = 1 << DEB_CNT_W;
`else
  localparam int DEB_WIN = 0;
`endif
  localparam int HIST = 64;
  logic clk = 0, resetn = 0;
  logic [NUM_CH-1:0] uin = '0, fin = '0, clr = '0, uout, fout, flag;
  logic [2*NUM_CH-1:0] mode = '0;
  int n_chk = 0, n_pass = 0;
  logic [NUM_CH-1:0] uq[$];
  logic [NUM_CH-1:0] f_cur, f_old, m_flag, fin_q, deb;

  always #5 clk = ~clk;

  user_io_bridge #(.NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES), .DEB_CNT_W(DEB_CNT_W)) dut (
    .UserCLK  (clk),
    .resetn   (resetn),
    .UIN      (uin),
    .UOUT     (uout),
    .FIN      (fin),
    .FOUT     (fout),
    .cfg_mode (mode),
    .edge_flag(flag),
    .edge_clr (clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    uq.delete();
    for (int k = 0; k < HIST; k++) uq.push_back('0);
    f_cur = '0; f_old = '0; m_flag = '0; fin_q = '0; deb = '0;
  endtask

  // filtered(): pin value from SYNC_STAGES-1 edges back, or (debounced) a value that
  // the synced pin has shown continuously for a full window
  task automatic model_edge();
    logic [NUM_CH-1:0] rise;
    rise = f_cur & ~f_old;
    m_flag = rise | (m_flag & ~clr);
    fin_q = fin;
    uq.push_back(uin);
    if (uq.size() > HIST) void'(uq.pop_front());
    f_old = f_cur;
`ifdef USER_IO_DEBOUNCE_EN
    for (int c = 0; c < NUM_CH; c++) begin
      bit all = 1;
      for (int j = 0; j < DEB_WIN; j++)
        if (uq[uq.size()-1-SYNC_STAGES-j][c] == deb[c]) all = 0;
      if (all) deb[c] = ~deb[c];
    end
    f_cur = deb;
`else
    f_cur = uq[uq.size()-SYNC_STAGES];
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    if (resetn) model_edge();
    @(negedge clk);
  endtask

  task automatic check_outputs(input string tag);
    logic [NUM_CH-1:0] eu, ef;
    for (int c = 0; c < NUM_CH; c++) begin
      case (mode[2*c +: 2])
        2'b00: begin eu[c] = fin[c];   ef[c] = uin[c];   end
        2'b01: begin eu[c] = fin[c];   ef[c] = f_cur[c]; end
        2'b10: begin eu[c] = fin_q[c]; ef[c] = f_cur[c]; end
        default: begin eu[c] = 1'b0;   ef[c] = fin_q[c]; end
      endcase
    end
    chk($sformatf("%s.uout", tag), 32'(uout), 32'(eu));
    chk($sformatf("%s.fout", tag), 32'(fout), 32'(ef));
    chk($sformatf("%s.flag", tag), 32'(flag), 32'(m_flag));
  endtask

  task automatic set_mode(input int c, input logic [1:0] m);
    mode[2*c +: 2] = m;
  endtask

  initial begin
    int n;
    logic [63:0] r64;
    logic [31:0] r;
    logic p7;
    // reset with inputs that would otherwise propagate
    uin = '1; fin = '1; mode = {NUM_CH{2'b10}};
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("rst.fout", 32'(fout), 0);
      chk("rst.uout", 32'(uout), 0);
      chk("rst.flag", 32'(flag), 0);
    end
    model_reset();
    uin = '0; fin = '0;
    resetn = 1;
    cyc();
    check_outputs("post_rst");
    // combinational pass-through, no clock edge between drive and check
    mode = '0;
    fin[3] = 1'b1; uin[5] = 1'b1;
    #1;
    chk("pass.uout3", 32'(uout[3]), 1);
    chk("pass.fout5", 32'(fout[5]), 1);
    check_outputs("pass");
    uin = '0; fin = '0;
    mode = {NUM_CH{2'b01}};
    clr = '1;
    for (int k = 0; k < 2*(SYNC_STAGES+DEB_WIN)+3; k++) cyc();
    clr = '0;
    cyc();
    check_outputs("idle");
    // synchroniser latency and flag timing on ch0
    uin[0] = 1'b1;
    n = 0;
    while (fout[0] !== 1'b1 && n < 100) begin cyc(); n++; end
    chk("sync_lat", n, SYNC_STAGES + DEB_WIN);
    chk("flag_pre", 32'(flag[0]), 0);
    cyc();
    chk("flag_post", 32'(flag[0]), 1);
    check_outputs("sync");
    // registered output latency
    set_mode(0, 2'b10);
    fin[0] = 1'b1;
    #1;
    chk("reg_pre", 32'(uout[0]), 0);
    cyc();
    chk("reg_lat", 32'(uout[0]), 1);
    // set wins over a simultaneous clear
    uin[2] = 1'b1;
    n = 0;
    while (!(f_cur[2] & ~f_old[2]) && n < 100) begin cyc(); check_outputs("race_wait"); n++; end
    chk("race_seen", 32'(n < 100), 1);
    clr[2] = 1'b1;
    cyc();
    chk("race_set", 32'(flag[2]), 1);
    check_outputs("race");
    cyc();
    chk("race_clr", 32'(flag[2]), 0);
    clr[2] = 1'b0;
    // loopback ignores the pin and follows FIN one cycle late
    set_mode(7, 2'b11);
    p7 = fin[7];
    for (int k = 0; k < 8; k++) begin
      fin[7] = ~fin[7];
      uin[7] = 1'($urandom);
      p7 = fin[7];
      cyc();
      chk("loop.fout7", 32'(fout[7]), 32'(p7));
      chk("loop.uout7", 32'(uout[7]), 0);
    end
`ifdef USER_IO_DEBOUNCE_EN
    set_mode(1, 2'b01);
    uin[1] = 1'b0;
    clr[1] = 1'b1;
    for (int k = 0; k < 2*DEB_WIN; k++) cyc();
    clr[1] = 1'b0;
    uin[1] = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    uin[1] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      chk("glitch.fout1", 32'(fout[1]), 0);
      chk("glitch.flag1", 32'(flag[1]), 0);
    end
    uin[1] = 1'b1;
    n = 0;
    while (fout[1] !== 1'b1 && n < 100) begin cyc(); n++; end
    chk("deb_lat", n, SYNC_STAGES + DEB_WIN);
`endif
    // randomized modes and sparse pin toggles
    for (int k = 0; k < 400; k++) begin
      if (k % 50 == 0) begin
        r64 = {$urandom(), $urandom()};
        mode = r64[2*NUM_CH-1:0];
      end
      r = $urandom() & $urandom() & $urandom() & $urandom() & $urandom();
      uin ^= r[NUM_CH-1:0];
      r = $urandom();
      fin = r[NUM_CH-1:0];
      r = $urandom() & $urandom();
      clr = r[NUM_CH-1:0];
      #1;
      check_outputs("rnd_comb");
      cyc();
      check_outputs("rnd");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
